// File: rtl/binary_to_bcd_seq.sv
// binary_to_bcd_seq
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// A start/busy/done handshake lets several display consumers share it.
// Optional feature macro: BCD_BLANK_EN (leading-zero blank flags per digit).
// Without BCD_BLANK_EN the blank port is tied to zero.

module binary_to_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      binary,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic [BCD_W-1:0]   work_adj;
  logic               ovf_acc_q, ovf_acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               overflow_q, overflow_d;
  logic               done_q, done_d;
  logic               carry_out;

  // Add-3 correction: every working digit of 5 or more gets +3 before the shift
  always_comb begin
    work_adj = work_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (work_q[4*k +: 4] >= 4'd5) begin
        work_adj[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // The bit leaving the top digit would start a digit we do not have: it marks overflow
  assign carry_out = work_adj[BCD_W-1];

  // Next-state and datapath control for the IDLE -> SHIFT -> LATCH sequence
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    work_d     = work_q;
    ovf_acc_d  = ovf_acc_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = binary;
          work_d    = '0;
          ovf_acc_d = 1'b0;
          cnt_d     = CNT_W'(BIN_W);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        {work_d, shift_d} = {work_adj[BCD_W-2:0], shift_q, 1'b0};
        ovf_acc_d         = ovf_acc_q | carry_out;
        cnt_d             = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        bcd_d      = work_q;
        overflow_d = ovf_acc_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any conversion in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      work_q     <= '0;
      ovf_acc_q  <= 1'b0;
      cnt_q      <= '0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      work_q     <= work_d;
      ovf_acc_q  <= ovf_acc_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = overflow_q;

`ifdef BCD_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  logic [DIGITS-1:0] blank_q, blank_d, blank_calc;

  // A digit is blank when it and every digit above it are zero; the ones digit never blanks
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    blank_calc = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above    = zero_above & (work_q[4*k +: 4] == 4'd0);
      blank_calc[k] = zero_above;
    end
  end

  // Blank flags change only together with bcd, when the result is latched
  always_comb begin
    blank_d = blank_q;
    if (state_q == LATCH) begin
      blank_d = blank_calc;
    end
  end

  // Blank flag register; reset shows a single lit zero in the ones digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q <= BLANK_RST;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`else
  assign blank = '0;
`endif

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// tb_binary_to_bcd_seq
// Self-checking bench for binary_to_bcd_seq. Three instances cover the
// 8-bit/3-digit, 8-bit/2-digit (overflow) and 16-bit/5-digit configurations.
// Expected results come from a decimal arithmetic model (value mod 10^DIGITS).

module tb_binary_to_bcd_seq;

  logic        clk;
  logic        rst_n;

  logic        start_a, start_b, start_c;
  logic [7:0]  bin_a, bin_b;
  logic [15:0] bin_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic [11:0] bcd_a;
  logic [7:0]  bcd_b;
  logic [19:0] bcd_c;
  logic        ovf_a, ovf_b, ovf_c;
  logic [2:0]  blank_a;
  logic [1:0]  blank_b;
  logic [4:0]  blank_c;

  int          tests;
  int          fails;
  int          sel;

  logic        cur_busy, cur_done, cur_ovf;
  logic [31:0] cur_bcd, cur_blank;

  binary_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .binary(bin_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a), .blank(blank_a));

  binary_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .binary(bin_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b), .blank(blank_b));

  binary_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .binary(bin_c),
    .busy(busy_c), .done(done_c), .bcd(bcd_c), .overflow(ovf_c), .blank(blank_c));

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Route the selected instance's outputs to common observation signals
  always_comb begin
    cur_busy  = busy_a;
    cur_done  = done_a;
    cur_ovf   = ovf_a;
    cur_bcd   = 32'(bcd_a);
    cur_blank = 32'(blank_a);
    case (sel)
      1: begin
        cur_busy  = busy_b;
        cur_done  = done_b;
        cur_ovf   = ovf_b;
        cur_bcd   = 32'(bcd_b);
        cur_blank = 32'(blank_b);
      end
      2: begin
        cur_busy  = busy_c;
        cur_done  = done_c;
        cur_ovf   = ovf_c;
        cur_bcd   = 32'(bcd_c);
        cur_blank = 32'(blank_c);
      end
      default: ;
    endcase
  end

  function automatic int width_of(input int s);
    return (s == 2) ? 16 : 8;
  endfunction

  function automatic int digits_of(input int s);
    return (s == 0) ? 3 : ((s == 1) ? 2 : 5);
  endfunction

  function automatic int pow10(input int n);
    int p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Decimal reference: digits of value mod 10^D, overflow when value >= 10^D
  task automatic model(input int d, input int value,
                       output logic [31:0] exp_bcd, output logic exp_ovf,
                       output logic [31:0] exp_blank);
    int m;
    int v;
    m         = value % pow10(d);
    v         = m;
    exp_bcd   = '0;
    exp_blank = '0;
    for (int k = 0; k < d; k++) begin
      exp_bcd = exp_bcd | (32'(v % 10) << (4 * k));
      v       = v / 10;
    end
    exp_ovf = (value >= pow10(d));
`ifdef BCD_BLANK_EN
    for (int k = 1; k < d; k++) begin
      exp_blank[k] = (m < pow10(k));
    end
`endif
  endtask

  function automatic logic [31:0] blank_reset(input int d);
    logic [31:0] r;
    r = '0;
`ifdef BCD_BLANK_EN
    for (int k = 1; k < d; k++) r[k] = 1'b1;
`endif
    return r;
  endfunction

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int s, input bit st, input int value);
    case (s)
      0: begin start_a = st; bin_a = 8'(value); end
      1: begin start_b = st; bin_b = 8'(value); end
      default: begin start_c = st; bin_c = 16'(value); end
    endcase
  endtask

  task automatic set_start(input int s, input bit st);
    case (s)
      0: start_a = st;
      1: start_b = st;
      default: start_c = st;
    endcase
  endtask

  task automatic checkOutput(input string tag, input int value);
    logic [31:0] eb;
    logic        eo;
    logic [31:0] ek;
    model(digits_of(sel), value, eb, eo, ek);
    compare({tag, "_bcd"}, cur_bcd, eb);
    compare({tag, "_ovf"}, 32'(cur_ovf), 32'(eo));
    compare({tag, "_blank"}, cur_blank, ek);
  endtask

  // Count negedges until done is seen, bounded so a dead DUT cannot hang the run
  task automatic wait_done(input int start_lat, output int lat);
    lat = start_lat;
    while (!cur_done && lat < 64) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  // One full conversion with latency, busy, pulse-width and hold checks
  task automatic run_conv(input string tag, input int s, input int value);
    int lat;
    sel = s;
    @(negedge clk);
    applyStimulus(s, 1'b1, value);
    @(posedge clk);
    @(negedge clk);
    set_start(s, 1'b0);
    compare({tag, "_busy_hi"}, 32'(cur_busy), 32'd1);
    wait_done(0, lat);
    compare({tag, "_latency"}, 32'(lat), 32'(width_of(s) + 1));
    compare({tag, "_busy_lo"}, 32'(cur_busy), 32'd0);
    checkOutput(tag, value);
    @(posedge clk);
    @(negedge clk);
    compare({tag, "_done_pulse"}, 32'(cur_done), 32'd0);
    checkOutput({tag, "_hold"}, value);
  endtask

  initial begin
    int lat;
    int seen;
    tests   = 0;
    fails   = 0;
    sel     = 0;
    rst_n   = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    bin_a   = '0;   bin_b   = '0;   bin_c   = '0;

    // Reset state
    #12;
    compare("rst_busy", 32'(busy_a), 32'd0);
    compare("rst_done", 32'(done_a), 32'd0);
    compare("rst_bcd", 32'(bcd_a), 32'd0);
    compare("rst_ovf", 32'(ovf_a), 32'd0);
    compare("rst_blank", 32'(blank_a), blank_reset(3));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed values from the plan
    run_conv("a255", 0, 255);
    run_conv("a0", 0, 0);
    run_conv("b99", 1, 99);
    run_conv("b123", 1, 123);
    run_conv("b200", 1, 200);

    // Start while busy ignored, late binary change ignored, then back-to-back start
    sel = 0;
    @(negedge clk);
    applyStimulus(0, 1'b1, 42);
    @(posedge clk);                  // E0
    @(negedge clk);
    start_a = 1'b0;
    @(posedge clk);                  // E1
    @(negedge clk);
    bin_a = 8'd7;
    @(posedge clk);                  // E2
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);                  // E3
    @(negedge clk);
    start_a = 1'b0;
    lat = 3;
    while (!cur_done && lat < 64) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (lat == 5) start_a = 1'b1;
    end
    compare("b2b_first_latency", 32'(lat), 32'd9);
    checkOutput("b2b_first", 42);
    @(posedge clk);                  // E10: start held through done cycle
    @(negedge clk);
    start_a = 1'b0;
    compare("b2b_second_busy", 32'(cur_busy), 32'd1);
    compare("b2b_second_done_lo", 32'(cur_done), 32'd0);
    wait_done(0, lat);
    compare("b2b_second_latency", 32'(lat), 32'd9);
    checkOutput("b2b_second", 7);

    // Reset in the middle of a conversion of 200
    @(negedge clk);
    applyStimulus(0, 1'b1, 200);
    @(posedge clk);                  // E0
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(posedge clk);       // E4
    #1;
    rst_n = 1'b0;
    #1;
    compare("abort_busy", 32'(busy_a), 32'd0);
    compare("abort_done", 32'(done_a), 32'd0);
    compare("abort_bcd", 32'(bcd_a), 32'd0);
    compare("abort_ovf", 32'(ovf_a), 32'd0);
    compare("abort_blank", 32'(blank_a), blank_reset(3));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done_a) seen++;
    end
    compare("abort_no_done", 32'(seen), 32'd0);
    run_conv("a200_after_abort", 0, 200);

    // Wide configuration
    run_conv("c65535", 2, 65535);
    run_conv("c1000", 2, 1000);

    // Randomized values on every configuration
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 6; i++) begin
        run_conv("rand", s, int'($urandom_range(0, (1 << width_of(s)) - 1)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
